move_button_encoder: RTL and testbench



---
 rtl/move_button_encoder_pkg.sv | 29 ++
 rtl/move_button_encoder_button_debouncer.sv | 50 +++++
 rtl/move_button_encoder.sv | 110 +++++++++++
 tb/tb_move_button_encoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_button_encoder_pkg.sv
// Shared definitions for the movement front end: the one-hot direction encoding
// (bit order shared with the player-position register) and FSM state encodings.
package move_button_encoder_pkg;

    localparam int DIR_W = 4;

    // Bit positions inside every 4-bit direction vector: {up, down, left, right}.
    localparam int BIT_UP    = 3;
    localparam int BIT_DOWN  = 2;
    localparam int BIT_LEFT  = 1;
    localparam int BIT_RIGHT = 0;

    localparam logic [DIR_W-1:0] DIR_UP    = 4'b1000;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 4'b0100;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 4'b0010;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 4'b0001;
    localparam logic [DIR_W-1:0] DIR_NONE  = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    function automatic logic isOneHot(input logic [DIR_W-1:0] v);
        return (v != '0) && ((v & (v - DIR_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/move_button_encoder_button_debouncer.sv
// Two-flop synchronizer plus counting debouncer for one raw push-button;
// held_o flips only after the synchronized input has differed for DEBOUNCE_CYCLES edges.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic held_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             held_q;
    logic             held_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    always_comb begin
        held_d = held_q;
        cnt_d  = '0;
        if (sync2_q != held_q) begin
            if (cnt_q == CNT_LAST) begin
                held_d = ~held_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            held_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
        end
    end

    assign held_o = held_q;

endmodule

// File: rtl/move_button_encoder.sv
// Turns four raw buttons into single-cycle one-hot move pulses: one pulse on
// press, then auto-repeat after REPEAT_DELAY and every REPEAT_PERIOD while held.
module move_button_encoder
    import move_button_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter int CNT_W           = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             enable,
    output logic [DIR_W-1:0] move,
    output logic [DIR_W-1:0] held
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [DIR_W-1:0] btnRaw;
    logic [DIR_W-1:0] heldLvl;
    logic             dirValid;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] rcnt_q;
    logic [CNT_W-1:0] rcnt_d;
    logic [CNT_W-1:0] rcntLast;
    logic [DIR_W-1:0] lastDir_q;
    logic [DIR_W-1:0] lastDir_d;
    logic [DIR_W-1:0] move_q;
    logic [DIR_W-1:0] move_d;

    assign btnRaw[BIT_UP]    = btn_up;
    assign btnRaw[BIT_DOWN]  = btn_down;
    assign btnRaw[BIT_LEFT]  = btn_left;
    assign btnRaw[BIT_RIGHT] = btn_right;

    for (genvar g = 0; g < DIR_W; g++) begin : gen_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debouncer (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_i (btnRaw[g]),
            .held_o(heldLvl[g])
        );
    end

    assign dirValid = isOneHot(heldLvl);
    assign rcntLast = (state_q == ST_DELAY) ? DELAY_LAST : PERIOD_LAST;

    // A release or direction change always beats a repeat that is due on the same edge.
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        lastDir_d = lastDir_q;
        move_d    = DIR_NONE;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && dirValid) begin
                    move_d    = heldLvl;
                    lastDir_d = heldLvl;
                    rcnt_d    = '0;
                    state_d   = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (!enable || !dirValid || (heldLvl != lastDir_q)) begin
                    rcnt_d  = '0;
                    state_d = ST_IDLE;
                end else if (rcnt_q == rcntLast) begin
                    move_d  = lastDir_q;
                    rcnt_d  = '0;
                    state_d = ST_REPEAT;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
            end
            default: begin
                rcnt_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rcnt_q    <= '0;
            lastDir_q <= DIR_NONE;
            move_q    <= DIR_NONE;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            lastDir_q <= lastDir_d;
            move_q    <= move_d;
        end
    end

    assign move = move_q;
    assign held = heldLvl;

endmodule

// File: tb/tb_move_button_encoder.sv
// Directed bench for move_button_encoder with short debounce/repeat timing; expected
// pulses are queued by cycle number and a negedge monitor checks move every cycle.
module tb_move_button_encoder;

    localparam logic [3:0] UP    = 4'b1000;
    localparam logic [3:0] DOWN  = 4'b0100;
    localparam logic [3:0] RIGHT = 4'b0001;
    localparam logic [3:0] NONE  = 4'b0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       enable;
    logic [3:0] move;
    logic [3:0] held;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    exp_t expQ[$];
    int   cyc     = 0;
    int   nAssert = 0;
    int   nFail   = 0;
    bit   monOn   = 1'b0;

    move_button_encoder #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .CNT_W          (24)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .enable   (enable),
        .move     (move),
        .held     (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every monitored cycle move must equal the queued pulse for that cycle, else 0000.
    always @(negedge clk) begin
        logic [3:0] expMove;
        expMove = NONE;
        if (monOn) begin
            if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
                expMove = expQ[0].val;
                void'(expQ.pop_front());
            end
            nAssert++;
            assert (move === expMove)
            else begin
                nFail++;
                $error("[TB] FAIL move cyc=%0d observed=%b expected=%b", cyc, move, expMove);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic u, input logic d, input logic l, input logic r);
        btn_up    = u;
        btn_down  = d;
        btn_left  = l;
        btn_right = r;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] expVal);
        nAssert++;
        assert (obs === expVal)
        else begin
            nFail++;
            $error("[TB] FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expVal);
        end
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic pushPulse(input int obsCyc, input logic [3:0] val);
        exp_t e;
        e.cyc = obsCyc;
        e.val = val;
        expQ.push_back(e);
    endtask

    // Pulse after edge base+first, first repeat 10 edges later, then every 3, while edge <= last.
    task automatic schedRepeat(input int base, input int first, input int last, input logic [3:0] val);
        int e;
        pushPulse(base + first + 1, val);
        e = first + 10;
        while (e <= last) begin
            pushPulse(base + e + 1, val);
            e += 3;
        end
    endtask

    initial begin
        int base;
        int s;
        int l;
        int m;

        rst_n  = 1'b0;
        enable = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        checkOutput("reset_move", move, NONE);
        checkOutput("reset_held", held, NONE);
        @(negedge clk);
        waitUntil(3);
        rst_n = 1'b1;
        monOn = 1'b1;
        waitUntil(cyc + 2);

        $display("[TB] clean up press with auto-repeat");
        base = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        schedRepeat(base, 6, 35, UP);
        waitUntil(base + 5);
        checkOutput("up_held_before", held, NONE);
        waitUntil(base + 6);
        checkOutput("up_held_after", held, UP);
        waitUntil(base + 30);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitUntil(base + 35);
        checkOutput("up_release_held_still", held, UP);
        waitUntil(base + 36);
        checkOutput("up_release_held_clear", held, NONE);
        waitUntil(base + 50);

        $display("[TB] bouncing right button");
        base = cyc;
        for (int i = 0; i < 10; i++) begin
            waitUntil(base + 4 * i);
            btn_right = 1'b1;
            checkOutput("bounce_held_hi", held, NONE);
            waitUntil(base + 4 * i + 2);
            btn_right = 1'b0;
            checkOutput("bounce_held_lo", held, NONE);
        end
        waitUntil(base + 40);
        s = cyc;
        btn_right = 1'b1;
        pushPulse(s + 7, RIGHT);
        waitUntil(s + 5);
        checkOutput("right_held_before", held, NONE);
        waitUntil(s + 6);
        checkOutput("right_held_after", held, RIGHT);
        waitUntil(s + 8);
        btn_right = 1'b0;
        waitUntil(s + 14);
        checkOutput("right_release_held", held, NONE);
        waitUntil(s + 25);

        $display("[TB] up and left together, then left released");
        base = cyc;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        waitUntil(base + 6);
        checkOutput("two_btn_held", held, 4'b1010);
        waitUntil(base + 15);
        l = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        pushPulse(l + 7, UP);
        waitUntil(l + 5);
        checkOutput("left_rel_held_still", held, 4'b1010);
        waitUntil(l + 6);
        checkOutput("left_rel_held_up", held, UP);
        waitUntil(l + 8);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitUntil(l + 14);
        checkOutput("two_btn_release_held", held, NONE);
        waitUntil(l + 25);

        $display("[TB] up repeating, then switch to down");
        base = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        schedRepeat(base, 6, 25, UP);
        schedRepeat(base, 27, 43, DOWN);
        waitUntil(base + 20);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        waitUntil(base + 25);
        checkOutput("switch_held_up", held, UP);
        waitUntil(base + 26);
        checkOutput("switch_held_down", held, DOWN);
        waitUntil(base + 38);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitUntil(base + 44);
        checkOutput("switch_release_held", held, NONE);
        waitUntil(base + 55);

        $display("[TB] enable low while up held, then enable high");
        base = cyc;
        enable = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitUntil(base + 10);
        checkOutput("disabled_held", held, UP);
        waitUntil(base + 40);
        s = cyc;
        enable = 1'b1;
        schedRepeat(s, 0, 19, UP);
        waitUntil(s + 14);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitUntil(s + 20);
        checkOutput("enable_release_held", held, NONE);
        waitUntil(s + 30);

        $display("[TB] asynchronous reset with a pulse in flight");
        base = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        pushPulse(base + 7, UP);
        waitUntil(base + 7);
        #2;
        rst_n = 1'b0;
        #1;
        monOn = 1'b0;
        checkOutput("async_reset_move", move, NONE);
        checkOutput("async_reset_held", held, NONE);
        waitUntil(cyc + 3);
        checkOutput("in_reset_move", move, NONE);
        checkOutput("in_reset_held", held, NONE);
        m = cyc;
        rst_n = 1'b1;
        monOn = 1'b1;
        pushPulse(m + 7, UP);
        waitUntil(m + 6);
        checkOutput("post_reset_held", held, UP);
        waitUntil(m + 8);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitUntil(m + 14);
        checkOutput("post_reset_release_held", held, NONE);
        waitUntil(m + 25);

        nAssert++;
        assert (expQ.size() == 0)
        else begin
            nFail++;
            $error("[TB] FAIL pending_pulses observed=%0d expected=0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
